fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage that drives instruction memory and buffers returned words in a small in-order queue.
- Presents the buffered words to the decode pipeline register with a valid/ready handshake.
- Sits between instruction memory and the IF/ID instruction register, directly upstream of decode.
- Handles taken-branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries and maximum outstanding memory requests; power of two, at least 2.
- XLEN, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle; meaningful only when imem_req=1.
- imem_rvalid  in  1  response word valid; responses return in request order, latency ≥1 cycle.
- imem_rdata  in  XLEN  response instruction word.
- redirect  in  1  taken branch/flush this cycle.
- redirect_pc  in  XLEN  new fetch address.
- inst_valid  out  1  queue head valid.
- inst  out  XLEN  head instruction, first-word-fall-through.
- inst_pc  out  XLEN  PC of head instruction.
- inst_ready  in  1  decode accepts head.
- occupancy  out  clog2(DEPTH+1)  current number of queue entries.

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
- Outputs after reset: inst_valid=0, occupancy=0, imem_req=0 during the reset cycle.
- Priority order: rst, then redirect, then normal operation.
- Request issue: imem_req = !rst & !redirect & (occupancy + outstanding < DEPTH).
- imem_addr = fetch_pc.
- On req&gnt: fetch_pc += 4, wrapping modulo 2^XLEN; outstanding += 1.
- Response with drop_cnt>0: word discarded; drop_cnt -= 1; outstanding -= 1.
- Response with drop_cnt=0: push {resp_pc, imem_rdata}; resp_pc += 4; outstanding -= 1.
- Simultaneous grant and response: outstanding is unchanged.
- Pop: occurs on inst_valid & inst_ready. Simultaneous push and pop leaves occupancy unchanged.
- Overflow cannot occur, because requests are gated by the credit rule (occupancy + outstanding < DEPTH). Overflow is an assertion failure in simulation.
- inst_valid = (occupancy != 0). inst and inst_pc come from the head entry. When inst_valid=0, inst and inst_pc are don't-care.
- Redirect cycle actions:
  - Queue cleared; any pop in this cycle is ignored.
  - fetch_pc and resp_pc set to {redirect_pc[XLEN-1:2], 2'b00}; misaligned low bits are forced to zero.
  - drop_cnt <= outstanding - imem_rvalid; a response arriving in the redirect cycle is itself discarded.
  - outstanding <= outstanding - imem_rvalid.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding count, so stale words are never enqueued.
- Redirect latency: first request to the new target in the cycle after redirect.
  - Earliest inst_valid for the target = 1 cycle after the target's rvalid.
  - Earliest inst_valid for the target = 2 cycles after the grant when memory latency is 1.
- Fetch-to-decode latency without bypass: rvalid at cycle N gives inst_valid at cycle N+1.
- Reset mid-operation clears all state. Instruction memory shares rst, so no pre-reset responses arrive after reset.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, drop_cnt=0, redirect=0 and imem_rvalid=1:
  - inst_valid=1, inst=imem_rdata and inst_pc=resp_pc in the same cycle.
  - If inst_ready=1, the word is consumed without being written into the queue.
  - Otherwise it is written into the queue normally.
- Not defined: no combinational path from imem_rvalid/imem_rdata to the inst outputs; one cycle latency as stated above.

Test Plan:
- Reset release with RESET_PC=0: cycle after rst falls, imem_req=1 and imem_addr=0x0; inst_valid=0 until the first response.
- Streaming (gnt=1 always, rvalid 1 cycle after grant, ready=1, rdata=0x00A00093+addr):
  - inst_pc sequence 0x0,0x4,0x8,0xC, one per cycle.
  - inst matches rdata for each PC.
- Backpressure (ready=0, DEPTH=4):
  - Exactly 4 grants, then imem_req=0; occupancy=4.
  - Raise ready: pops 0x0..0xC in order, then requests resume at 0x10.
- Redirect with 2 outstanding (redirect_pc=0x100, memory latency 3):
  - The next 2 rvalid words are discarded.
  - First inst_valid shows inst_pc=0x100; occupancy never includes stale words.
- Misaligned redirect (redirect_pc=0x103) with a simultaneous rvalid: response dropped; next imem_addr=0x100.
- rst asserted with full queue and outstanding requests: next cycle occupancy=0, inst_valid=0, imem_addr=RESET_PC; no stale instruction is ever output.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch: issues word fetches under a credit limit, buffers in-order responses, flushes on redirect.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when nothing is queued ahead of it.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         inst_valid,
    output logic [XLEN-1:0]              inst,
    output logic [XLEN-1:0]              inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [XLEN-1:0] target;
    logic            issue;
    logic            accept;
    logic            bypass;
    logic            push;
    logic            pop;

    assign target    = redirect_pc & ~XLEN'(3);
    // Credit rule: queued words plus in-flight requests never exceed the queue size.
    assign imem_req  = !rst && !redirect && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;
    assign accept    = imem_rvalid && (drop_cnt == '0) && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass  = accept && (count == '0);
    assign inst    = bypass ? imem_rdata : q_data[rd_ptr];
    assign inst_pc = bypass ? resp_pc    : q_pc[rd_ptr];
`else
    assign bypass  = 1'b0;
    assign inst    = q_data[rd_ptr];
    assign inst_pc = q_pc[rd_ptr];
`endif

    assign push       = accept && !(bypass && inst_ready);
    assign pop        = (count != '0) && inst_ready && !redirect;
    assign inst_valid = (count != '0) || bypass;
    assign occupancy  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Everything still in flight is stale, including a word arriving right now.
            fetch_pc    <= target;
            resp_pc     <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop_cnt    <= outstanding - CW'(imem_rvalid);
        end else begin
            if (issue)  fetch_pc <= fetch_pc + XLEN'(4);
            if (accept) resp_pc  <= resp_pc + XLEN'(4);
            if (push)   wr_ptr   <= wr_ptr + PW'(1);
            if (pop)    rd_ptr   <= rd_ptr + PW'(1);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count == DEPTH_C)));
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model feeding a scoreboard, a per-cycle vector table, and corner sequences.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] OPC      = 32'h00A0_0093;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic [CW-1:0]   occupancy;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_occ;
        logic [31:0] e_pc;
    } vec_t;

    req_t        mem_q[$];
    exp_t        sb[$];
    logic [31:0] model_pc;
    int          cyc;
    int          lat;
    int          gnt_rand;
    int          pops;
    int          total;
    int          bad;
    vec_t        no_v;
    vec_t        tab[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (n) begin
            #2;
            check("req_in_reset", {31'b0, imem_req}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        mem_q.delete();
        sb.delete();
        model_pc = RESET_PC;
        cyc = 0;
        pops = 0;
    endtask

    task automatic run_cycle(input logic rdy, input logic redir, input logic [31:0] rpc,
                             input bit use_v, input vec_t v);
        bit          resp;
        bit          resp_stale;
        logic [31:0] resp_addr;
        bit          exp_req;
        resp = 1'b0; resp_stale = 1'b0; resp_addr = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            resp       = 1'b1;
            resp_addr  = mem_q[0].addr;
            resp_stale = mem_q[0].stale;
            mem_q.delete(0);
        end
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rvalid = resp;
        imem_rdata  = resp ? resp_addr + OPC : 32'hDEAD_BEEF;
        imem_gnt    = (gnt_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        exp_req = !redir && ((sb.size() + mem_q.size() + (resp ? 1 : 0)) < DEPTH);
        check("occupancy", 32'(occupancy), sb.size());
        check("inst_valid", {31'b0, inst_valid}, {31'b0, sb.size() != 0});
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, model_pc);
        if (use_v) begin
            check("vec_req", {31'b0, imem_req}, {31'b0, v.e_req});
            if (v.e_req) check("vec_addr", imem_addr, v.e_addr);
            check("vec_valid", {31'b0, inst_valid}, {31'b0, v.e_valid});
            check("vec_occ", 32'(occupancy), v.e_occ);
            if (v.e_valid) check("vec_pc", inst_pc, v.e_pc);
        end
        if (!redir && rdy && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("inst", inst, e.data);
            check("inst_pc", inst_pc, e.pc);
            pops++;
        end
        if (redir) begin
            sb.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            model_pc = rpc & ~32'h3;
        end else begin
            if (exp_req && imem_gnt) begin
                mem_q.push_back('{model_pc, cyc + lat, 1'b0});
                model_pc = model_pc + 32'd4;
            end
            if (resp && !resp_stale) sb.push_back('{resp_addr, resp_addr + OPC});
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        int w;
        total = 0; bad = 0; gnt_rand = 0; lat = 1;
        no_v = '{default: '0};

        // ready, req, addr, valid, occ, head pc -- backpressure fill then drain, latency 1
        tab[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 0, 32'h0};
        tab[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 0, 32'h0};
        tab[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 1, 32'h0};
        tab[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 2, 32'h0};
        tab[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 3, 32'h0};
        tab[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 4, 32'h0};
        tab[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 4, 32'h0};
        tab[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 4, 32'h0};
        tab[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 3, 32'h4};
        tab[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 2, 32'h8};
        tab[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 2, 32'hC};

        do_reset(2);
        for (int i = 0; i < 11; i++) run_cycle(tab[i].ready, 1'b0, 32'h0, 1'b1, tab[i]);
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        // Streaming from reset: one instruction per cycle from cycle 2 on
        do_reset(1);
        lat = 1;
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);
        check("stream_pops", pops, 6);

        // Redirect with two requests in flight, memory latency 3
        do_reset(1);
        lat = 3;
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);
        check("redir_outstanding", mem_q.size(), 2);
        run_cycle(1'b1, 1'b1, 32'h100, 1'b0, no_v);
        w = 0;
        while (!inst_valid && w < 20) begin
            run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);
            w++;
        end
        check("redir_latency", w, 4);
        check("redir_first_pc", inst_pc, 32'h100);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        // Misaligned redirect coinciding with a response
        do_reset(1);
        lat = 1;
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0, no_v);
        check("misalign_rvalid_due", mem_q.size(), 1);
        run_cycle(1'b0, 1'b1, 32'h103, 1'b0, no_v);
        redirect = 1'b0;
        #1;
        check("misalign_addr", imem_addr, 32'h100);
        check("misalign_occ", 32'(occupancy), 0);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        // Reset while words are queued and requests are in flight
        lat = 3;
        run_cycle(1'b1, 1'b1, 32'h200, 1'b0, no_v);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b0, no_v);
        check("pre_reset_occ", 32'(occupancy), 2);
        check("pre_reset_outstanding", mem_q.size(), 2);
        do_reset(1);
        #1;
        check("post_reset_occ", 32'(occupancy), 0);
        check("post_reset_valid", {31'b0, inst_valid}, 32'h0);
        check("post_reset_addr", imem_addr, RESET_PC);
        lat = 1;
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        // Address wrap at the top of the address space
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, no_v);
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        // Random grants, ready, latency and occasional redirects
        gnt_rand = 1;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), $urandom, 1'b0, no_v);
        end
        gnt_rand = 0;
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, no_v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
